uart_ram_loader: RTL and testbench

- Command-driven bridge between a byte-stream UART receiver/transmitter pair and port A of the byte-enabled 32-bit dual-port block RAM.
- The host uses it to write arbitrary byte ranges into RAM and to read ranges back. Port B stays free for the consumer logic.
- Sits directly upstream of the RAM on its write/read port A and downstream of the UART RX byte deserializer.

---
 rtl/uart_ram_loader.sv | 133 +++++++++++++
 tb/tb_uart_ram_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_loader.sv
// uart_ram_loader: UART command bridge that writes and reads byte ranges through RAM port A
module uart_ram_loader #(
   parameter int ADDRESS_BITWIDTH = 10,
   parameter logic [7:0] ACK_BYTE = 8'h4B
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic [7:0]                  rx_data,
   input  logic                        rx_valid,
   output logic [7:0]                  tx_data,
   output logic                        tx_valid,
   input  logic                        tx_ready,
   output logic [3:0]                  ram_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0] ram_address,
   output logic [31:0]                 ram_data_in,
   input  logic [31:0]                 ram_data_out,
   output logic                        busy,
   output logic                        error
);
   localparam int AW = ADDRESS_BITWIDTH + 2;
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] LEN   = 3'd2;
   localparam logic [2:0] WDATA = 3'd3;
   localparam logic [2:0] ACK   = 3'd4;
   localparam logic [2:0] RADDR = 3'd5;
   localparam logic [2:0] RWAIT = 3'd6;
   localparam logic [2:0] RSEND = 3'd7;

   logic [2:0]    state;
   logic          is_write;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_next;
   logic [15:0]   count;
   logic [15:0]   len_full;
   logic [1:0]    idx;
   logic [1:0]    lane;

   assign addr_next = addr + AW'(1);
   assign lane      = addr[1:0];
   assign len_full  = {rx_data, count[15:8]};
   assign busy      = state != IDLE;

   // Command parser, RAM port A sequencing and TX byte handshake
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state            <= IDLE;
         is_write         <= 1'b0;
         addr             <= '0;
         count            <= '0;
         idx              <= '0;
         ram_write_enable <= '0;
         ram_address      <= '0;
         ram_data_in      <= '0;
         tx_data          <= '0;
         tx_valid         <= 1'b0;
         error            <= 1'b0;
      end else begin
         ram_write_enable <= '0;
         error            <= 1'b0;
         case (state)
            IDLE: if (rx_valid) begin
               if (rx_data == 8'h57 || rx_data == 8'h52) begin
                  is_write <= rx_data == 8'h57;
                  idx      <= '0;
                  state    <= ADDR;
               end else begin
                  error <= 1'b1;
               end
            end
            ADDR: if (rx_valid) begin
               for (int i = 0; i < AW; i++)
                  if (idx == 2'(i / 8)) addr[i] <= rx_data[i % 8];
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  idx   <= '0;
                  state <= LEN;
               end
            end
            LEN: if (rx_valid) begin
               count <= len_full;
               idx   <= idx + 2'd1;
               if (idx == 2'd1) begin
                  idx <= '0;
                  if (len_full == 16'd0) begin
                     state <= is_write ? ACK : IDLE;
                  end else if (is_write) begin
                     state <= WDATA;
                  end else begin
                     ram_address <= addr[AW-1:2];
                     state       <= RADDR;
                  end
               end
            end
            WDATA: if (rx_valid) begin
               ram_address      <= addr[AW-1:2];
               ram_data_in      <= {4{rx_data}};
               ram_write_enable <= 4'b0001 << lane;
               addr             <= addr_next;
               count            <= count - 16'd1;
               if (count == 16'd1) state <= ACK;
            end
            ACK: begin
               if (!tx_valid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= ACK_BYTE;
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            RADDR: state <= RWAIT;
            RWAIT: begin
               tx_data  <= ram_data_out[8*lane +: 8];
               tx_valid <= 1'b1;
               state    <= RSEND;
            end
            RSEND: if (tx_ready) begin
               tx_valid <= 1'b0;
               addr     <= addr_next;
               count    <= count - 16'd1;
               if (count == 16'd1) begin
                  state <= IDLE;
               end else begin
                  ram_address <= addr_next[AW-1:2];
                  state       <= RADDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: randomized frames checked against a byte-array model of RAM and TX stream
module tb_uart_ram_loader;
   localparam int NB = 4096;

   typedef struct packed {
      logic [9:0]  a;
      logic [3:0]  we;
      logic [31:0] d;
   } wr_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [3:0]  ram_write_enable;
   logic [9:0]  ram_address;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;
   logic        busy;
   logic        error;

   logic [31:0] mem [1024];
   logic [7:0]  refmem [NB];
   wr_t         wr_q [$];
   wr_t         exp_wr [$];
   logic [7:0]  tx_q [$];
   logic [7:0]  exp_tx [$];
   logic [7:0]  payload [$];
   int          wr_rd = 0;
   int          tx_rd = 0;
   int          ready_mode = 0;
   int          passed = 0;
   int          total = 0;
   int          viol = 0;
   time         last_hs_t = 0;
   logic        hold = 1'b0;
   logic [7:0]  hold_data = 8'h00;

   uart_ram_loader #(.ADDRESS_BITWIDTH(10), .ACK_BYTE(8'h4B)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .ram_write_enable(ram_write_enable), .ram_address(ram_address),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy), .error(error)
   );

   always #5 sys_clk = ~sys_clk;

   // Byte-enabled RAM with registered port A read, preloaded with random contents
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      forever begin
         @(posedge sys_clk);
         for (int l = 0; l < 4; l++)
            if (ram_write_enable[l]) mem[ram_address][8*l +: 8] <= ram_data_in[8*l +: 8];
         ram_data_out <= mem[ram_address];
      end
   end

   // Transmitter acceptance: always ready, random, or held off 5 cycles per byte
   initial begin
      int lc;
      lc = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (ready_mode == 0) begin
            tx_ready = 1'b1;
         end else if (ready_mode == 1) begin
            tx_ready = 1'($urandom_range(0, 1));
         end else if (!tx_valid) begin
            lc = 0;
            tx_ready = 1'b0;
         end else begin
            lc++;
            tx_ready = lc > 5;
         end
      end
   end

   // Observe RAM writes and TX handshakes; flag TX instability or TX overlapping a write
   always @(negedge sys_clk) begin
      if (ram_write_enable != 4'b0) wr_q.push_back('{ram_address, ram_write_enable, ram_data_in});
      if (tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         last_hs_t <= $time;
      end
      if (!sys_rst && hold && (!tx_valid || tx_data !== hold_data)) viol <= viol + 1;
      else if (tx_valid && ram_write_enable != 4'b0) viol <= viol + 1;
      hold      <= !sys_rst && tx_valid && !tx_ready;
      hold_data <= tx_data;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic header(input logic [7:0] cmd, input logic [31:0] a, input int n);
      send(cmd);
      chk("cmd_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
      send(n[7:0]);
      send(n[15:8]);
   endtask

   task automatic wr_frame(input logic [31:0] a, input int n, input int sent, input bit ack);
      header(8'h57, a, n);
      for (int i = 0; i < sent; i++) begin
         logic [7:0] b;
         int p;
         b = (i < payload.size()) ? payload[i] : 8'($urandom);
         p = int'((a + 32'(i)) % 32'(NB));
         exp_wr.push_back('{10'(p / 4), 4'(1 << (p % 4)), {4{b}}});
         refmem[p] = b;
         send(b);
      end
      if (ack) exp_tx.push_back(8'h4B);
      payload.delete();
   endtask

   task automatic rd_frame(input logic [31:0] a, input int n);
      header(8'h52, a, n);
      for (int i = 0; i < n; i++) exp_tx.push_back(refmem[int'((a + 32'(i)) % 32'(NB))]);
   endtask

   task automatic finish_frame(input string tag, input bit fall);
      int c;
      c = 0;
      @(negedge sys_clk);
      while (busy && c < 3000) begin
         @(negedge sys_clk);
         c++;
      end
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      if (fall) chk({tag, "_busy_fall"}, 64'($time - last_hs_t), 64'd10);
      chk({tag, "_nwr"}, 64'(wr_q.size() - wr_rd), 64'(exp_wr.size()));
      foreach (exp_wr[i]) begin
         wr_t o;
         o = (wr_rd + i < wr_q.size()) ? wr_q[wr_rd + i] : '1;
         chk({tag, "_wr"}, 64'(o), 64'(exp_wr[i]));
      end
      chk({tag, "_ntx"}, 64'(tx_q.size() - tx_rd), 64'(exp_tx.size()));
      foreach (exp_tx[i]) begin
         logic [7:0] o;
         o = (tx_rd + i < tx_q.size()) ? tx_q[tx_rd + i] : 8'hxx;
         chk({tag, "_tx"}, 64'(o), 64'(exp_tx[i]));
      end
      wr_rd = wr_q.size();
      tx_rd = tx_q.size();
      exp_wr.delete();
      exp_tx.delete();
      @(posedge sys_clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      int n, bad;
      sys_rst  = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #1;
      for (int i = 0; i < NB; i++) refmem[i] = mem[i / 4][8*(i % 4) +: 8];
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_we", 64'(ram_write_enable), 64'd0);
      chk("rst_tx_valid", 64'(tx_valid), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_addr", 64'(ram_address), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_data_in", 64'(ram_data_in), 64'd0);
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;

      rx_data  = 8'h00;
      rx_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      rx_valid = 1'b0;
      chk("bad_error_on", 64'(error), 64'd1);
      chk("bad_busy", 64'(busy), 64'd0);
      @(posedge sys_clk);
      #1;
      chk("bad_error_off", 64'(error), 64'd0);

      payload = '{8'h11, 8'h22, 8'h33, 8'h44};
      wr_frame(32'h1, 4, 4, 1'b1);
      finish_frame("w_plan", 1'b0);
      chk("portb_word0", 64'(mem[0][31:8]), 64'h332211);

      ready_mode = 0;
      rd_frame(32'h1, 3);
      finish_frame("r_plan", 1'b1);

      ready_mode = 2;
      rd_frame(32'h0, 6);
      finish_frame("r_stall", 1'b0);
      ready_mode = 0;

      payload = '{8'hAA, 8'hBB};
      wr_frame(32'h0000_0FFF, 2, 2, 1'b1);
      finish_frame("w_wrap", 1'b0);
      chk("wrap_hi", 64'(mem[1023][31:24]), 64'hAA);
      chk("wrap_lo", 64'(mem[0][7:0]), 64'hBB);

      wr_frame(32'h0000_0123, 0, 0, 1'b1);
      finish_frame("w_len0", 1'b0);
      rd_frame(32'h0000_0123, 0);
      finish_frame("r_len0", 1'b0);

      wr_frame(32'h0000_0200, 5, 2, 1'b0);
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_we", 64'(ram_write_enable), 64'd0);
      chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
      finish_frame("midrst", 1'b0);
      ready_mode = 1;
      rd_frame(32'h0000_0200, 2);
      finish_frame("r_after_rst", 1'b0);

      for (int k = 0; k < 6; k++) begin
         ready_mode = k % 3;
         a = $urandom;
         n = $urandom_range(1, 6);
         wr_frame(a, n, n, 1'b1);
         finish_frame("w_rand", 1'b0);
         rd_frame(a - 32'd1, n + 2);
         finish_frame("r_rand", 1'b0);
      end

      bad = 0;
      for (int i = 0; i < NB; i++)
         if (mem[i / 4][8*(i % 4) +: 8] !== refmem[i]) bad++;
      chk("portb_all", 64'(bad), 64'd0);
      chk("invariants", 64'(viol), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
